mat_outer_prod: RTL and testbench
=================================

# mat_outer_prod

Streaming source that sits upstream of the 3x3 matrix accumulator. It loads two 3x3 signed 8-bit matrices A and B over an AXI-stream slave. It then emits the three outer-product partial matrices P_k = A[:,k]·B[k,:] (k = 0, 1, 2) as 27 consecutive beats on an AXI-stream master. The accumulator sums those three 9-element frames to form A·B.

## Interface
Parameters:
- DATA_W, 8: element width, signed two's complement.
- N, 3: matrix dimension. Frame length is N·N. Only N = 3 is verified.

Ports:
- i_clk, in, 1: the single clock. Everything is on its rising edge.
- i_rst, in, 1: reset, synchronous and active-high.
- i_clk_e, in, 1: clock enable. When low, all state, counters and registers hold.
- s_axis_data, in, DATA_W: signed input element. A is sent first, row-major, then B, row-major.
- s_axis_valid, in, 1: input beat valid.
- s_axis_ready, out, 1: high in the LOAD state.
- s_axis_last, in, 1: ignored. Beat counts alone define framing.
- m_axis_data, out, DATA_W: signed partial-product element.
- m_axis_valid, out, 1: high in the EMIT state.
- m_axis_ready, in, 1: downstream accept.
- m_axis_last, out, 1: high on the final (27th) beat only.

## Operation
- States are LOAD and EMIT.
- **LOAD state**
  - A beat is accepted when i_clk_e && s_axis_valid && s_axis_ready.
  - Load index ld 0..8 writes A[ld/3][ld%3]. Load index 9..17 writes B[(ld-9)/3][(ld-9)%3].
  - When beat 17 is accepted: ld is set to 0, k, r and c are set to 0, and the state goes to EMIT.
- **EMIT state**
  - A beat transfers when i_clk_e && m_axis_valid && m_axis_ready.
  - Output element: m_axis_data = low DATA_W bits of A[r][k]*B[k][c]. The full product is 2·DATA_W signed and is truncated with wrap; there is no saturation.
  - Order: c is the innermost counter, then r, then k. Frame k outputs element r·3+c.
  - m_axis_last = (k==2 && r==2 && c==2).
  - When the last beat transfers, the state returns to LOAD.
- **Counter requirement:** r and c are separate 0..2 counters. No divide or modulo operators are used on indices.
- **Backpressure:** while m_axis_valid && !m_axis_ready, m_axis_data and m_axis_last stay stable.
- **Input during EMIT:** s_axis_ready=0. Input data is not sampled, and A and B do not change during EMIT.
- **Reset:** i_rst wins over i_clk_e. Reset values:
  - state LOAD, so s_axis_ready=1 on the cycle after the reset edge.
  - m_axis_valid=0 and m_axis_last=0.
  - all counters 0.
  - A and B cleared to 0, so m_axis_data=0.
- **Reset mid-LOAD or mid-EMIT:** the partial transfer is discarded. The next accepted beat is A[0][0].

## Timing
- m_axis_data and m_axis_last are combinational from the A/B registers and counters. m_axis_valid and s_axis_ready decode directly from the state register.
- The first output beat is presented in the cycle after the 18th input beat is accepted.
- Throughput with valid/ready held high is 18 load cycles plus 27 emit cycles, i.e. 45 cycles per product.
- i_clk_e low stalls both sides. No transfer is counted even if both valid and ready are high.
- The 18th input accept and the first output beat can never fall in the same cycle.

## Structure
- Shared package mat_pkg holds:
  - MAT_N=3, MAT_ELEMS=9, MAT_DATA_W=8
  - the state enum (LOAD, EMIT)
  - LD_BEATS=18 and EMIT_BEATS=27
- One sub-module is natural: mat_idx_ctr. It is an enabled nested r/c/k counter with a wrap flag and a last flag. The same counter can be reused for the load index as a flat 0..17 count.
- The multiplier is inferred inline. No DSP primitive is instantiated.

## Test plan
1. **Identity times ramp.** A=I, B=1..9 row-major, ready held high. Required frames:
   - k0: 1,2,3,0,0,0,0,0,0
   - k1: 0,0,0,4,5,6,0,0,0
   - k2: 0,0,0,0,0,0,7,8,9
   - m_axis_last high only on beat 27, and that beat is 9.
2. **Wrap.** A all 16, B all 16: every output is 0x00 (256 wraps). Then A[0][0]=-128 with B[0][0]=-1: the first beat is -128 (0x80).
3. **Backpressure.** m_axis_ready toggles pseudo-randomly. Required:
   - the output sequence equals case 1;
   - data and last are stable during every stall;
   - exactly 27 beats transfer.
4. **Clock enable.** i_clk_e is low for 5 cycles at beat 4 of EMIT with valid/ready high. No index advance occurs, and beat 4 is presented again when i_clk_e returns high.
5. **Reset mid-LOAD.** Assert i_rst after 10 accepted beats. Required:
   - next cycle: s_axis_ready=1, m_axis_valid=0, m_axis_data=0;
   - a fresh 18-beat load then produces the correct case-1 output.
6. **Input gaps and ignored input.** s_axis_valid has gaps during LOAD, and garbage with valid high is driven during EMIT. Required: the gaps do not shift indices, s_axis_ready=0 throughout EMIT, and the output is unchanged.

Source files
------------

// File: rtl/mat_pkg.sv
// rtl/mat_pkg.sv - shared constants and state type for the outer-product source
package mat_pkg;

  localparam int MAT_N      = 3;
  localparam int MAT_ELEMS  = 9;
  localparam int MAT_DATA_W = 8;
  localparam int LD_BEATS   = 18;
  localparam int EMIT_BEATS = 27;

  typedef enum logic {
    LOAD = 1'b0,
    EMIT = 1'b1
  } state_t;

endpackage

// File: rtl/mat_idx_ctr.sv
// rtl/mat_idx_ctr.sv - enabled nested c/r/k index counter with last and wrap flags
module mat_idx_ctr #(
  parameter int N     = 3,
  parameter int K_CNT = 3,
  parameter int W     = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  output logic [W-1:0] o_r,
  output logic [W-1:0] o_c,
  output logic [W-1:0] o_k,
  output logic         o_last,
  output logic         o_wrap
);

  localparam logic [W-1:0] RC_MAX = W'(N - 1);
  localparam logic [W-1:0] K_MAX  = W'(K_CNT - 1);

  logic [W-1:0] r_q, r_d;
  logic [W-1:0] c_q, c_d;
  logic [W-1:0] k_q, k_d;

  // c is innermost, then r, then k; everything returns to zero after the last position
  always_comb begin
    r_d = r_q;
    c_d = c_q;
    k_d = k_q;
    if (i_en) begin
      if (c_q == RC_MAX) begin
        c_d = '0;
        if (r_q == RC_MAX) begin
          r_d = '0;
          k_d = (k_q == K_MAX) ? '0 : k_q + W'(1);
        end else begin
          r_d = r_q + W'(1);
        end
      end else begin
        c_d = c_q + W'(1);
      end
    end
  end

  // index registers, reset to the first position
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= '0;
      c_q <= '0;
      k_q <= '0;
    end else begin
      r_q <= r_d;
      c_q <= c_d;
      k_q <= k_d;
    end
  end

  assign o_r    = r_q;
  assign o_c    = c_q;
  assign o_k    = k_q;
  assign o_last = (k_q == K_MAX) && (r_q == RC_MAX) && (c_q == RC_MAX);
  assign o_wrap = i_en && o_last;

endmodule

// File: rtl/mat_outer_prod.sv
// rtl/mat_outer_prod.sv - loads A and B, then streams the three outer-product frames
module mat_outer_prod
  import mat_pkg::*;
#(
  parameter int DATA_W = MAT_DATA_W,
  parameter int N      = MAT_N
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clk_e,
  input  logic [DATA_W-1:0] s_axis_data,
  input  logic              s_axis_valid,
  output logic              s_axis_ready,
  input  logic              s_axis_last,
  output logic [DATA_W-1:0] m_axis_data,
  output logic              m_axis_valid,
  input  logic              m_axis_ready,
  output logic              m_axis_last
);

  localparam int IDX_W = $clog2(N);
  localparam int PW    = 2 * DATA_W;

  state_t state_q, state_d;

  logic signed [DATA_W-1:0] a_q [0:N-1][0:N-1];
  logic signed [DATA_W-1:0] b_q [0:N-1][0:N-1];

  logic             in_acc, out_xfer;
  logic [IDX_W-1:0] ld_r, ld_c, ld_k;
  logic [IDX_W-1:0] em_r, em_c, em_k;
  logic             ld_wrap, em_wrap, em_last;
  logic             ld_last_unused;
  logic             s_last_unused;
  logic signed [PW-1:0]     a_ext, b_ext, prod;
  logic        [DATA_W-1:0] prod_unused_hi;

  // framing comes from beat counts alone
  assign s_last_unused = s_axis_last;

  assign s_axis_ready = (state_q == LOAD);
  assign m_axis_valid = (state_q == EMIT);
  assign in_acc       = i_clk_e && s_axis_valid && s_axis_ready;
  assign out_xfer     = i_clk_e && m_axis_valid && m_axis_ready;

  // load index: k=0 selects A, k=1 selects B, r/c give the row-major position
  mat_idx_ctr #(.N(N), .K_CNT(LD_BEATS / MAT_ELEMS), .W(IDX_W)) u_ld_ctr (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (in_acc),
    .o_r    (ld_r),
    .o_c    (ld_c),
    .o_k    (ld_k),
    .o_last (ld_last_unused),
    .o_wrap (ld_wrap)
  );

  // emit index: frame k, element r*N+c
  mat_idx_ctr #(.N(N), .K_CNT(EMIT_BEATS / MAT_ELEMS), .W(IDX_W)) u_em_ctr (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (out_xfer),
    .o_r    (em_r),
    .o_c    (em_c),
    .o_k    (em_k),
    .o_last (em_last),
    .o_wrap (em_wrap)
  );

  // state register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= LOAD;
    else       state_q <= state_d;
  end

  // next state: leave LOAD on the 18th accept, leave EMIT on the 27th transfer
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (in_acc && ld_wrap)    state_d = EMIT;
      EMIT:    if (out_xfer && em_wrap)  state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // matrix storage, written only by accepted load beats
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_q[i][j] <= '0;
          b_q[i][j] <= '0;
        end
      end
    end else if (in_acc) begin
      if (ld_k == '0) a_q[ld_r][ld_c] <= s_axis_data;
      else            b_q[ld_r][ld_c] <= s_axis_data;
    end
  end

  // full signed product, truncated with wrap to the element width
  assign a_ext = PW'(a_q[em_r][em_k]);
  assign b_ext = PW'(b_q[em_k][em_c]);
  assign prod  = a_ext * b_ext;
  assign {prod_unused_hi, m_axis_data} = prod;
  assign m_axis_last = em_last;

endmodule

// File: tb/tb_mat_outer_prod.sv
// tb/tb_mat_outer_prod.sv - randomized and directed checks of mat_outer_prod against a matrix model
module tb_mat_outer_prod;

  logic       clk = 1'b0;
  logic       rst, ce;
  logic [7:0] s_data;
  logic       s_valid, s_ready, s_last;
  logic [7:0] m_data;
  logic       m_valid, m_ready, m_last;

  int         tests = 0;
  int         fails = 0;
  int         a_m [9];
  int         b_m [9];
  logic [7:0] exp_q [27];
  int         cyc;

  always #5 clk = ~clk;

  mat_outer_prod dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_clk_e      (ce),
    .s_axis_data  (s_data),
    .s_axis_valid (s_valid),
    .s_axis_ready (s_ready),
    .s_axis_last  (s_last),
    .m_axis_data  (m_data),
    .m_axis_valid (m_valid),
    .m_axis_ready (m_ready),
    .m_axis_last  (m_last)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // P_k[r][c] = A[r][k] * B[k][c], low 8 bits, frames in k order
  function automatic void build_model();
    for (int k = 0; k < 3; k++)
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          exp_q[k*9 + r*3 + c] = 8'(a_m[r*3 + k] * b_m[k*3 + c]);
  endfunction

  function automatic void set_ident_ramp();
    for (int i = 0; i < 9; i++) begin
      a_m[i] = (i % 4 == 0) ? 1 : 0;
      b_m[i] = i + 1;
    end
  endfunction

  function automatic void set_random();
    for (int i = 0; i < 9; i++) begin
      a_m[i] = $signed(8'($urandom));
      b_m[i] = $signed(8'($urandom));
    end
  endfunction

  task automatic load(input int nbeats, input bit gaps);
    for (int i = 0; i < nbeats; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          @(negedge clk);
          s_valid = 1'b0;
          s_data  = 8'($urandom);
          s_last  = 1'($urandom);
        end
      end
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = (i < 9) ? 8'(a_m[i]) : 8'(b_m[i-9]);
      s_last  = 1'($urandom);
      chk($sformatf("s_ready_load[%0d]", i), s_ready, 1);
    end
  endtask

  task automatic collect(input bit bp, input bit garbage, input int ce_at, output int cycles);
    int         beat = 0;
    int         ce_pt = ce_at;
    bit         stalled = 0;
    logic [7:0] hd = '0;
    logic       hl = 1'b0;
    cycles = 0;
    while (beat < 27 && cycles < 400) begin
      @(negedge clk);
      cycles++;
      s_valid = garbage;
      s_data  = 8'($urandom);
      m_ready = bp ? 1'($urandom) : 1'b1;
      chk("s_ready_emit", s_ready, 0);
      chk("m_valid_emit", m_valid, 1);
      if (stalled) begin
        chk($sformatf("stall_data[%0d]", beat), m_data, hd);
        chk($sformatf("stall_last[%0d]", beat), m_last, hl);
      end
      if (ce_pt >= 0 && beat == ce_pt) begin
        ce      = 1'b0;
        m_ready = 1'b1;
        repeat (5) begin
          @(negedge clk);
          cycles++;
          chk($sformatf("ce_hold_data[%0d]", beat), m_data, exp_q[beat]);
          chk("ce_hold_valid", m_valid, 1);
        end
        ce    = 1'b1;
        ce_pt = -1;
      end
      if (m_ready) begin
        chk($sformatf("data[%0d]", beat), m_data, exp_q[beat]);
        chk($sformatf("last[%0d]", beat), m_last, (beat == 26));
        beat++;
        stalled = 0;
      end else begin
        hd      = m_data;
        hl      = m_last;
        stalled = 1;
      end
    end
    chk("beats_transferred", beat, 27);
    @(negedge clk);
    s_valid = 1'b0;
    m_ready = 1'b0;
    chk("post_m_valid", m_valid, 0);
    chk("post_s_ready", s_ready, 1);
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; s_data = '0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
    rst = 1'b0;

    // identity times ramp, full throughput
    set_ident_ramp(); build_model();
    load(18, 0);
    collect(0, 0, -1, cyc);
    chk("emit_cycles", cyc, 27);

    // wrap: 16*16 = 256 -> 0
    for (int i = 0; i < 9; i++) begin a_m[i] = 16; b_m[i] = 16; end
    build_model();
    load(18, 0);
    collect(0, 0, -1, cyc);

    // wrap: -128 * -1 = 128 -> 0x80
    set_random();
    a_m[0] = -128; b_m[0] = -1;
    build_model();
    load(18, 0);
    collect(0, 0, -1, cyc);

    // backpressure
    set_ident_ramp(); build_model();
    load(18, 0);
    collect(1, 0, -1, cyc);

    // clock enable low for 5 cycles at beat 4
    load(18, 0);
    collect(0, 0, 4, cyc);

    // reset after 10 accepted beats
    set_random(); build_model();
    load(10, 0);
    @(negedge clk);
    s_valid = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_s_ready", s_ready, 1);
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_m_data", m_data, 0);
    set_ident_ramp(); build_model();
    load(18, 0);
    collect(0, 0, -1, cyc);

    // input gaps and garbage during EMIT
    load(18, 1);
    collect(0, 1, -1, cyc);

    // random products with gaps, garbage and backpressure
    for (int t = 0; t < 4; t++) begin
      set_random(); build_model();
      load(18, 1);
      collect(1, 1, -1, cyc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
